// File: rtl/lcd_img_ctrl_if.sv
// Bus bundle for lcd_img_ctrl: command handshake, image ROM port and
// result buffer port. The controller uses the slave view, its
// environment (host, ROM, buffer) the master view.
interface lcd_img_ctrl_if #(
  parameter int DW = 8,
  parameter int XW = 3,
  parameter int YW = 3
);
  logic [3:0]       cmd;
  logic             cmd_valid;
  logic [DW-1:0]    IROM_Q;
  logic             IROM_EN;
  logic [XW+YW-1:0] IROM_A;
  logic             IRB_RW;
  logic [DW-1:0]    IRB_D;
  logic [XW+YW-1:0] IRB_A;
  logic             busy;
  logic             done;

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
  );
endinterface

// File: rtl/lcd_img_ctrl.sv
// Image-window controller: loads a 2^XW x 2^YW image from ROM, then
// moves/transforms a 2x2 window on command and streams the image to
// the result buffer on WRITE.
// Optional feature macro: LCD_ROTATE_EN (enables ROT_CW/ROT_CCW;
// without it opcodes 10/11 are one-cycle no-ops).
//
// state   | meaning
// S_LOAD  | copy ROM into pixel array after reset
// S_IDLE  | waiting for cmd_valid
// S_EXEC  | one-cycle move / mirror / rotate / no-op
// S_SCAN  | four-cycle scan TL,TR,BL,BR for AVERAGE/MAX/MIN
// S_WBACK | write reduced value to all four window pixels
// S_WRITE | stream pixel array to result buffer
module lcd_img_ctrl #(
  parameter int DW = 8,
  parameter int XW = 3,
  parameter int YW = 3
) (
  input logic           clk,
  input logic           reset,
  lcd_img_ctrl_if.slave bus
);

  localparam int AW = XW + YW;
  localparam int N  = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam logic [XW-1:0] X0   = XW'((1 << XW) / 2 - 1);
  localparam logic [YW-1:0] Y0   = YW'((1 << YW) / 2 - 1);
  localparam logic [XW-1:0] XMAX = XW'((1 << XW) - 2);
  localparam logic [YW-1:0] YMAX = YW'((1 << YW) - 2);

  localparam logic [3:0] OP_WRITE   = 4'd0;
  localparam logic [3:0] OP_UP      = 4'd1;
  localparam logic [3:0] OP_DOWN    = 4'd2;
  localparam logic [3:0] OP_LEFT    = 4'd3;
  localparam logic [3:0] OP_RIGHT   = 4'd4;
  localparam logic [3:0] OP_AVG     = 4'd5;
  localparam logic [3:0] OP_MIRR_X  = 4'd6;
  localparam logic [3:0] OP_MIRR_Y  = 4'd7;
  localparam logic [3:0] OP_MAX     = 4'd8;
  localparam logic [3:0] OP_MIN     = 4'd9;
`ifdef LCD_ROTATE_EN
  localparam logic [3:0] OP_ROT_CW  = 4'd10;
  localparam logic [3:0] OP_ROT_CCW = 4'd11;
`endif

  typedef enum logic [2:0] {
    S_LOAD, S_IDLE, S_EXEC, S_SCAN, S_WBACK, S_WRITE
  } state_t;

  state_t state, next_state;

  logic [DW-1:0] pix [N];

  logic [3:0]    op;
  logic [XW-1:0] x, x_nx;
  logic [YW-1:0] y, y_nx;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  logic [DW-1:0] p_tl, p_tr, p_bl, p_br;
  logic [1:0]    scan_idx;
  logic [DW-1:0] scan_px;
  logic [DW+1:0] acc;
  logic [DW-1:0] ext;
  logic          take;
  logic [DW-1:0] red_val;
  logic          irom_en;
  logic [AW-1:0] irom_a;
  logic          irb_rw;
  logic [AW-1:0] irb_a;
  logic [DW-1:0] irb_d;
  logic          done_r;

  // Window never touches the last column/row at its origin, so +1 never wraps.
  assign x_nx = x + XW'(1);
  assign y_nx = y + YW'(1);
  assign a_tl = {y, x};
  assign a_tr = {y, x_nx};
  assign a_bl = {y_nx, x};
  assign a_br = {y_nx, x_nx};
  assign p_tl = pix[a_tl];
  assign p_tr = pix[a_tr];
  assign p_bl = pix[a_bl];
  assign p_br = pix[a_br];

  assign bus.IROM_EN = irom_en;
  assign bus.IROM_A  = irom_a;
  assign bus.IRB_RW  = irb_rw;
  assign bus.IRB_A   = irb_a;
  assign bus.IRB_D   = irb_d;
  assign bus.done    = done_r;
  assign bus.busy    = (state != S_IDLE);

  // Pick the pixel being scanned and the reduced writeback value.
  always_comb begin
    scan_px = p_tl;
    case (scan_idx)
      2'd1:    scan_px = p_tr;
      2'd2:    scan_px = p_bl;
      2'd3:    scan_px = p_br;
      default: scan_px = p_tl;
    endcase
    take    = (op == OP_MAX) ? (scan_px > ext) : (scan_px < ext);
    red_val = (op == OP_AVG) ? DW'(acc >> 2) : ext;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_LOAD:  if (!irom_en && irom_a == LAST) next_state = S_IDLE;
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            OP_WRITE:               next_state = S_WRITE;
            OP_AVG, OP_MAX, OP_MIN: next_state = S_SCAN;
            default:                next_state = S_EXEC;
          endcase
        end
      end
      S_EXEC:  next_state = S_IDLE;
      S_SCAN:  if (scan_idx == 2'd3) next_state = S_WBACK;
      S_WBACK: next_state = S_IDLE;
      S_WRITE: if (irb_a == LAST) next_state = S_IDLE;
      default: next_state = S_LOAD;
    endcase
  end

  // Control datapath: ROM sequencing, window position, scan, buffer stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op       <= '0;
      x        <= X0;
      y        <= Y0;
      scan_idx <= '0;
      acc      <= '0;
      ext      <= '0;
      irom_en  <= 1'b1;
      irom_a   <= '0;
      irb_rw   <= 1'b1;
      irb_a    <= '0;
      irb_d    <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= (state == S_WRITE) && (irb_a == LAST);
      case (state)
        S_LOAD: begin
          if (irom_en)              irom_en <= 1'b0;
          else if (irom_a == LAST)  irom_en <= 1'b1;
          else                      irom_a  <= irom_a + AW'(1);
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op       <= bus.cmd;
            scan_idx <= '0;
            if (bus.cmd == OP_WRITE) begin
              irb_rw <= 1'b0;
              irb_a  <= '0;
              irb_d  <= pix[{AW{1'b0}}];
            end
          end
        end
        S_EXEC: begin
          case (op)
            OP_UP:    if (y != '0)   y <= y - YW'(1);
            OP_DOWN:  if (y != YMAX) y <= y_nx;
            OP_LEFT:  if (x != '0)   x <= x - XW'(1);
            OP_RIGHT: if (x != XMAX) x <= x_nx;
            default: ;
          endcase
        end
        S_SCAN: begin
          scan_idx <= scan_idx + 2'd1;
          if (scan_idx == 2'd0) begin
            acc <= (DW+2)'(scan_px);
            ext <= scan_px;
          end else begin
            acc <= acc + (DW+2)'(scan_px);
            if (take) ext <= scan_px;
          end
        end
        S_WRITE: begin
          if (irb_a == LAST) begin
            irb_rw <= 1'b1;
          end else begin
            irb_a <= irb_a + AW'(1);
            irb_d <= pix[irb_a + AW'(1)];
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel array: ROM fill, window transforms and reduction writeback.
  always_ff @(posedge clk) begin
    case (state)
      S_LOAD: if (!irom_en) pix[irom_a] <= bus.IROM_Q;
      S_EXEC: begin
        case (op)
          OP_MIRR_X: begin
            pix[a_tl] <= p_bl;
            pix[a_bl] <= p_tl;
            pix[a_tr] <= p_br;
            pix[a_br] <= p_tr;
          end
          OP_MIRR_Y: begin
            pix[a_tl] <= p_tr;
            pix[a_tr] <= p_tl;
            pix[a_bl] <= p_br;
            pix[a_br] <= p_bl;
          end
`ifdef LCD_ROTATE_EN
          OP_ROT_CW: begin
            pix[a_tl] <= p_bl;
            pix[a_tr] <= p_tl;
            pix[a_br] <= p_tr;
            pix[a_bl] <= p_br;
          end
          OP_ROT_CCW: begin
            pix[a_tl] <= p_tr;
            pix[a_tr] <= p_br;
            pix[a_br] <= p_bl;
            pix[a_bl] <= p_tl;
          end
`endif
          default: ;
        endcase
      end
      S_WBACK: begin
        pix[a_tl] <= red_val;
        pix[a_tr] <= red_val;
        pix[a_bl] <= red_val;
        pix[a_br] <= red_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_img_ctrl.sv
// Directed bench for lcd_img_ctrl with default geometry (8x8, 8-bit),
// ROM[i] = i. Expected images are kept in img[] and edited by hand
// after each operation.
module tb_lcd_img_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [7:0] rom [64];
  logic [7:0] img [64];

  lcd_img_ctrl_if #(.DW(8), .XW(3), .YW(3)) bus ();

  lcd_img_ctrl #(.DW(8), .XW(3), .YW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.IROM_Q = rom[bus.IROM_A];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fresh_img();
    for (int i = 0; i < 64; i++) img[i] = rom[i];
  endtask

  task automatic do_reset();
    int n;
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_irom_en", bus.IROM_EN, 1);
    chk("rst_irom_a",  bus.IROM_A, 0);
    chk("rst_irb_rw",  bus.IRB_RW, 1);
    chk("rst_irb_d",   bus.IRB_D, 0);
    chk("rst_irb_a",   bus.IRB_A, 0);
    chk("rst_busy",    bus.busy, 1);
    chk("rst_done",    bus.done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk("load_en_low", bus.IROM_EN, 0);
        chk("load_a0",     bus.IROM_A, 0);
      end
    end while (bus.busy && n < 200);
    chk("load_len", n, 65);
    chk("load_en_high", bus.IROM_EN, 1);
    fresh_img();
  endtask

  task automatic issue(input logic [3:0] c);
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_idle", bus.busy, 0);
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("accept_busy", bus.busy, 1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input int exp_len);
    int n;
    issue(c);
    n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, exp_len);
  endtask

  task automatic do_write();
    issue(4'd0);
    for (int k = 0; k < 64; k++) begin
      chk("wr_rw",   bus.IRB_RW, 0);
      chk("wr_addr", bus.IRB_A, k);
      chk("wr_data", bus.IRB_D, img[k]);
      chk("wr_busy", bus.busy, 1);
      @(posedge clk); #1;
    end
    chk("wr_done",     bus.done, 1);
    chk("wr_busy_end", bus.busy, 0);
    chk("wr_rw_end",   bus.IRB_RW, 1);
    chk("wr_a_end",    bus.IRB_A, 63);
    @(posedge clk); #1;
    chk("wr_done_clr", bus.done, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 8'(i);
    #1;

    do_reset();
    do_write();
    do_write();

    // AVERAGE at (3,3) with a RIGHT held on cmd_valid during busy
    issue(4'd5);
    bus.cmd = 4'd4;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.busy && n < 20) begin
      if (n == 3) bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    chk("avg_len", n, 5);
    @(posedge clk); #1;
    chk("held_cmd_ignored", bus.busy, 0);
    img[27] = 8'd31; img[28] = 8'd31; img[35] = 8'd31; img[36] = 8'd31;
    // window still at (3,3): MAX over four 31s stays 31
    run_op("max_len", 4'd8, 5);
    do_write();

    // reset in the middle of a WRITE
    issue(4'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("midwr_rw", bus.IRB_RW, 0);
    chk("midwr_a",  bus.IRB_A, 10);
    do_reset();

    run_op("max_len", 4'd8, 5);
    run_op("min_len", 4'd9, 5);
    img[27] = 8'd36; img[28] = 8'd36; img[35] = 8'd36; img[36] = 8'd36;
    do_write();

    do_reset();
    run_op("min_len", 4'd9, 5);
    img[27] = 8'd27; img[28] = 8'd27; img[35] = 8'd27; img[36] = 8'd27;
    do_write();

    // saturate to (6,6), then mirror
    do_reset();
    for (int i = 0; i < 5; i++) run_op("right_len", 4'd4, 1);
    for (int i = 0; i < 5; i++) run_op("down_len", 4'd2, 1);
    run_op("mirr_y_len", 4'd7, 1);
    img[54] = 8'd55; img[55] = 8'd54; img[62] = 8'd63; img[63] = 8'd62;
    do_write();
    run_op("mirr_x_len", 4'd6, 1);
    img[54] = 8'd63; img[55] = 8'd62; img[62] = 8'd55; img[63] = 8'd54;
    do_write();

    // saturate to (0,0), rotate, undo, no-ops
    for (int i = 0; i < 7; i++) run_op("up_len", 4'd1, 1);
    for (int i = 0; i < 7; i++) run_op("left_len", 4'd3, 1);
    run_op("rot_cw_len", 4'd10, 1);
`ifdef LCD_ROTATE_EN
    img[0] = 8'd8; img[1] = 8'd0; img[8] = 8'd9; img[9] = 8'd1;
`endif
    do_write();
    run_op("rot_ccw_len", 4'd11, 1);
    img[0] = 8'd0; img[1] = 8'd1; img[8] = 8'd8; img[9] = 8'd9;
    run_op("nop12_len", 4'd12, 1);
    run_op("nop15_len", 4'd15, 1);
    do_write();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
